sseg_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment driver for the board display. It is the next generation of the fixed four-digit driver: digit count, refresh divider and PWM dimming width are parameters. It generates its own scan tick from the system clock instead of using a derived clock. Inputs are captured once per frame, and it adds per-digit blanking, brightness control and anode dead-time. It sits between user logic (adders, counters, game state) and the board's cathode and anode pins.

---
 rtl/sseg_pkg.sv | 22 ++
 rtl/sseg_hex_decode.sv | 12 +
 rtl/sseg_scan_driver.sv | 134 +++++++++++++
 tb/tb_sseg_scan_driver.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
// Segment encodings are active-low {dp,g,f,e,d,c,b,a}.
package sseg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'hFF;
  // Widest legal anode vector; users slice it down to NUM_DIGITS bits.
  localparam logic [7:0] AN_OFF = 8'hFF;

  localparam seg_t SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nib, input logic dp);
    seg_t raw;
    raw = SEG_TABLE[nib];
    return {~dp, raw[6:0]};
  endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to active-low segment pattern, with decimal point.
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output seg_t       seg_o
);

  assign seg_o = hex_to_seg(nib_i, dp_i);

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment scanner: prescaled digit slots, frame-coherent
// input shadowing, PWM dimming and one dark cycle per slot against ghosting.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 100000,
  parameter int PWM_BITS   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [7:0]              segment_cathodes,
  output logic [NUM_DIGITS-1:0]   digit_anodes,
  output logic                    scan_tick
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("sseg_scan_driver: NUM_DIGITS must be in 1..8");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("sseg_scan_driver: CLK_DIV must be at least 2");
  end
  if (PWM_BITS < 1) begin : g_bad_pwm_bits
    $error("sseg_scan_driver: PWM_BITS must be at least 1");
  end

  localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRESC_W-1:0]    PRESC_MAX = PRESC_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE   = AN_OFF[NUM_DIGITS-1:0];

  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PWM_BITS-1:0]     pwm_q, pwm_d;
  logic [4*NUM_DIGITS-1:0] dig_sh_q, dig_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
  logic [PWM_BITS-1:0]     bright_sh_q, bright_sh_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  seg_t                    seg_q, seg_d;

  logic       tick;
  logic       frame_end;
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_blank;
  logic       lit;

  assign tick      = (presc_q == PRESC_MAX);
  assign frame_end = tick && (idx_q == IDX_MAX);

  // Select the active digit's shadowed nibble, dp and blank flags.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = dig_sh_q[4*i +: 4];
        cur_dp    = dp_sh_q[i];
        cur_blank = blank_sh_q[i];
      end
    end
  end

  sseg_hex_decode u_decode (
    .nib_i (cur_nib),
    .dp_i  (cur_dp),
    .seg_o (seg_d)
  );

  // The tick cycle is forced dark so the next digit never overlaps the last.
  assign lit = !cur_blank && (pwm_q <= bright_sh_q) && !tick;

  always_comb begin
    an_d = AN_IDLE;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = !(lit && (idx_q == IDX_W'(i)));
    end
  end

  always_comb begin
    presc_d     = tick ? '0 : presc_q + PRESC_W'(1);
    idx_d       = idx_q;
    pwm_d       = pwm_q + PWM_BITS'(1);
    dig_sh_d    = dig_sh_q;
    dp_sh_d     = dp_sh_q;
    blank_sh_d  = blank_sh_q;
    bright_sh_d = bright_sh_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
    if (frame_end) begin
      dig_sh_d    = digits;
      dp_sh_d     = dp_en;
      blank_sh_d  = blank;
      bright_sh_d = brightness;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      pwm_q       <= '0;
      dig_sh_q    <= '0;
      dp_sh_q     <= '0;
      blank_sh_q  <= AN_IDLE;
      bright_sh_q <= '0;
      an_q        <= AN_IDLE;
      seg_q       <= SEG_OFF;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      pwm_q       <= pwm_d;
      dig_sh_q    <= dig_sh_d;
      dp_sh_q     <= dp_sh_d;
      blank_sh_q  <= blank_sh_d;
      bright_sh_q <= bright_sh_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign segment_cathodes = seg_q;
  assign digit_anodes     = an_q;
  assign scan_tick        = tick;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with 4 digits, 4-cycle slots, 2-bit PWM.
module tb_sseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp_en;
  logic [3:0]  blank;
  logic [1:0]  brightness;
  logic [7:0]  segment_cathodes;
  logic [3:0]  digit_anodes;
  logic        scan_tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  sseg_scan_driver #(
    .NUM_DIGITS (4),
    .CLK_DIV    (4),
    .PWM_BITS   (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .digits           (digits),
    .dp_en            (dp_en),
    .blank            (blank),
    .brightness       (brightness),
    .segment_cathodes (segment_cathodes),
    .digit_anodes     (digit_anodes),
    .scan_tick        (scan_tick)
  );

  // Clock and global watchdog.
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          cyc;
    logic        apply;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [1:0]  bright;
    logic [3:0]  an;
    logic [7:0]  cath;
    logic        tick;
  } vec_t;

  vec_t vecs[$];

  // Driver tasks: advance one cycle and sample #1 after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input int c, input logic [3:0] an, input logic [7:0] cath,
                     input logic tick);
    vec_t v;
    v = '{cyc: c, apply: 1'b0, digits: 16'h0, dp: 4'h0, blank: 4'h0, bright: 2'h0,
          an: an, cath: cath, tick: tick};
    vecs.push_back(v);
  endtask

  task automatic add_in(input int c, input logic [3:0] an, input logic [7:0] cath,
                        input logic tick, input logic [15:0] d, input logic [3:0] dp,
                        input logic [3:0] bl, input logic [1:0] br);
    vec_t v;
    v = '{cyc: c, apply: 1'b1, digits: d, dp: dp, blank: bl, bright: br,
          an: an, cath: cath, tick: tick};
    vecs.push_back(v);
  endtask

  initial begin
    // Reset state and first (dark) frame; shadow loads at cycle 15.
    add(0,  4'hF, 8'hFF, 1'b0);
    add(1,  4'hF, 8'hC0, 1'b0);
    add(2,  4'hF, 8'hC0, 1'b0);
    add(3,  4'hF, 8'hC0, 1'b1);
    add(4,  4'hF, 8'hC0, 1'b0);
    add(7,  4'hF, 8'hC0, 1'b1);
    add(11, 4'hF, 8'hC0, 1'b1);
    add(15, 4'hF, 8'hC0, 1'b1);
    add(16, 4'hF, 8'hC0, 1'b0);
    // Scan order with 8421 at full brightness.
    add(17, 4'hE, 8'hF9, 1'b0);
    add(18, 4'hE, 8'hF9, 1'b0);
    add(19, 4'hE, 8'hF9, 1'b1);
    add(20, 4'hF, 8'hF9, 1'b0);
    add(21, 4'hD, 8'hA4, 1'b0);
    add_in(22, 4'hD, 8'hA4, 1'b0, 16'hFFFF, 4'h0, 4'h0, 2'd3);
    add(24, 4'hF, 8'hA4, 1'b0);
    add(25, 4'hB, 8'h99, 1'b0);
    add(29, 4'h7, 8'h80, 1'b0);
    add(31, 4'h7, 8'h80, 1'b1);
    add_in(32, 4'hF, 8'h80, 1'b0, 16'h3210, 4'b0001, 4'b0100, 2'd0);
    // Frame after the mid-frame change shows F everywhere.
    add(33, 4'hE, 8'h8E, 1'b0);
    add(37, 4'hD, 8'h8E, 1'b0);
    add(41, 4'hB, 8'h8E, 1'b0);
    add(45, 4'h7, 8'h8E, 1'b0);
    // Blank on digit 2, dp on digit 0, minimum brightness.
    add(49, 4'hE, 8'h40, 1'b0);
    add(50, 4'hF, 8'h40, 1'b0);
    add(51, 4'hF, 8'h40, 1'b1);
    add(52, 4'hF, 8'h40, 1'b0);
    add(53, 4'hD, 8'hF9, 1'b0);
    add(54, 4'hF, 8'hF9, 1'b0);
    add(57, 4'hF, 8'hA4, 1'b0);
    add(58, 4'hF, 8'hA4, 1'b0);
    add(61, 4'h7, 8'hB0, 1'b0);
    add(62, 4'hF, 8'hB0, 1'b0);
    add(73, 4'hF, 8'hA4, 1'b0);

    // Reset block.
    rst        = 1'b1;
    digits     = 16'h8421;
    dp_en      = 4'h0;
    blank      = 4'h0;
    brightness = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    foreach (vecs[k]) begin
      if (vecs[k].cyc < cyc) begin
        check("vector_order", 32'(cyc), 32'(vecs[k].cyc));
      end else begin
        while (cyc < vecs[k].cyc) step();
        check("anodes",    32'(digit_anodes),     32'(vecs[k].an));
        check("cathodes",  32'(segment_cathodes), 32'(vecs[k].cath));
        check("scan_tick", 32'(scan_tick),        32'(vecs[k].tick));
        if (vecs[k].apply) begin
          digits     = vecs[k].digits;
          dp_en      = vecs[k].dp;
          blank      = vecs[k].blank;
          brightness = vecs[k].bright;
        end
      end
    end

    // Mid-frame reset during digit 2's slot (cycle 73).
    digits     = 16'h3210;
    dp_en      = 4'h0;
    blank      = 4'h0;
    brightness = 2'd3;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    check("rst_mid_anodes",   32'(digit_anodes),     32'h0000_000F);
    check("rst_mid_cathodes", 32'(segment_cathodes), 32'h0000_00FF);
    check("rst_mid_tick",     32'(scan_tick),        32'h0);
    step();
    check("rst_mid_idx0_cath", 32'(segment_cathodes), 32'h0000_00C0);
    for (int c = 1; c <= 16; c++) begin
      while (cyc < c) step();
      check("rst_mid_dark", 32'(digit_anodes), 32'h0000_000F);
      if (c == 3 || c == 7 || c == 11 || c == 15)
        check("rst_mid_tick_pos", 32'(scan_tick), 32'h1);
    end
    while (cyc < 17) step();
    check("rst_mid_lit_an",   32'(digit_anodes),     32'h0000_000E);
    check("rst_mid_lit_cath", 32'(segment_cathodes), 32'h0000_00C0);
    while (cyc < 21) step();
    check("rst_mid_d1_an",   32'(digit_anodes),     32'h0000_000D);
    check("rst_mid_d1_cath", 32'(segment_cathodes), 32'h0000_00F9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
